// File: rtl/dds_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dds_sample_sequencer
// Purpose  : Walks a waveform RAM and presents sample pairs (Y[n-1], Y[n-2])
//            to a downstream DDS interpolator once per sample period P.
//            Optional one-shot mode: define DDS_ONESHOT_EN to add the OneShot
//            input and the Done output.
// Revision : 1.0  initial release
// ============================================================================
module dds_sample_sequencer (
  input  logic        Fg_CLK,
  input  logic        Fg_RESETn,
  input  logic        Run,
  input  logic [2:0]  DDSMode,
  input  logic [9:0]  WaveLast,
  output logic [9:0]  MemAddr,
  output logic        MemRdEn,
  input  logic [31:0] MemData,
`ifdef DDS_ONESHOT_EN
  input  logic        OneShot,
  output logic        Done,
`endif
  output logic [31:0] out_1,
  output logic [31:0] out_2,
  output logic        DDSEnable,
  output logic        Busy
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRIME      = 2'd1,
    PRIME_WAIT = 2'd2,
    RUN        = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [13:0] count, count_nxt;
  logic [13:0] period_m1;
  logic        single;
  logic [2:0]  mode_q;
  logic        mode_changed;
  logic        rd_pending;
  logic [31:0] prefetch;
  logic [31:0] data_now;
  logic [9:0]  addr_adv, addr_nxt;
  logic        rden_nxt, en_nxt, tick, start_ok;
  logic [31:0] out1_nxt, out2_nxt;

`ifdef DDS_ONESHOT_EN
  logic wrap_seen, wrap_nxt, lock, lock_nxt, done_nxt;
  assign start_ok = ~lock;
`else
  assign start_ok = 1'b1;
`endif

  // Sample period minus one; 1 for the unused modes so they behave like mode 0
  always_comb begin
    case (DDSMode)
      3'd1:    period_m1 = 14'd9;
      3'd2:    period_m1 = 14'd99;
      3'd3:    period_m1 = 14'd999;
      3'd4:    period_m1 = 14'd9999;
      default: period_m1 = 14'd0;
    endcase
  end

  assign single       = (period_m1 == 14'd0);
  assign mode_changed = (DDSMode != mode_q);
  // ">=" so that lowering WaveLast below the current address still wraps
  assign addr_adv     = (MemAddr >= WaveLast) ? 10'd0 : MemAddr + 10'd1;
  // Freshly returned RAM word takes priority over the held prefetch copy
  assign data_now     = rd_pending ? MemData : prefetch;
  assign Busy         = (state != IDLE);

  // State register
  always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
    if (!Fg_RESETn) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state and next-output decode; a tick advances the sample pair
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    addr_nxt  = MemAddr;
    rden_nxt  = 1'b0;
    en_nxt    = 1'b0;
    out1_nxt  = out_1;
    out2_nxt  = out_2;
    tick      = 1'b0;
`ifdef DDS_ONESHOT_EN
    wrap_nxt  = wrap_seen;
    lock_nxt  = lock & Run;
    done_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        count_nxt = 14'd0;
        addr_nxt  = 10'd0;
        if (Run && start_ok) begin
          state_nxt = PRIME;
          rden_nxt  = 1'b1;
        end
      end
      PRIME: begin
        state_nxt = PRIME_WAIT;
        // With P=1 reads must stream back to back, so issue the second early
        if (single) begin
          rden_nxt = 1'b1;
          addr_nxt = addr_adv;
        end
      end
      PRIME_WAIT: begin
        state_nxt = RUN;
        count_nxt = 14'd0;
        tick      = single;
      end
      RUN: begin
`ifdef DDS_ONESHOT_EN
        if (wrap_seen) begin
          state_nxt = IDLE;
          count_nxt = 14'd0;
          addr_nxt  = 10'd0;
          wrap_nxt  = 1'b0;
          lock_nxt  = 1'b1;
          done_nxt  = 1'b1;
        end else
`endif
        if (mode_changed) begin
          count_nxt = 14'd0;
        end else if (count == period_m1) begin
          tick      = 1'b1;
          count_nxt = 14'd0;
        end else begin
          count_nxt = count + 14'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (tick) begin
      out2_nxt = out_1;
      out1_nxt = data_now;
      en_nxt   = 1'b1;
      rden_nxt = 1'b1;
      addr_nxt = addr_adv;
`ifdef DDS_ONESHOT_EN
      if (OneShot && (addr_adv == 10'd0)) wrap_nxt = 1'b1;
`endif
    end

    // Dropping Run stops from any active state, holding the output pair
    if ((state != IDLE) && !Run) begin
      state_nxt = IDLE;
      count_nxt = 14'd0;
      addr_nxt  = 10'd0;
      rden_nxt  = 1'b0;
      en_nxt    = 1'b0;
      out1_nxt  = out_1;
      out2_nxt  = out_2;
`ifdef DDS_ONESHOT_EN
      wrap_nxt  = 1'b0;
      done_nxt  = 1'b0;
`endif
    end
  end

  // Datapath registers: counter, read port, prefetch and output pair
  always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
    if (!Fg_RESETn) begin
      count      <= 14'd0;
      MemAddr    <= 10'd0;
      MemRdEn    <= 1'b0;
      rd_pending <= 1'b0;
      prefetch   <= 32'd0;
      out_1      <= 32'd0;
      out_2      <= 32'd0;
      DDSEnable  <= 1'b0;
      mode_q     <= 3'd0;
    end else begin
      count      <= count_nxt;
      MemAddr    <= addr_nxt;
      MemRdEn    <= rden_nxt;
      rd_pending <= MemRdEn;
      if (rd_pending) prefetch <= MemData;
      out_1      <= out1_nxt;
      out_2      <= out2_nxt;
      DDSEnable  <= en_nxt;
      mode_q     <= DDSMode;
    end
  end

`ifdef DDS_ONESHOT_EN
  // One-shot bookkeeping: wrap seen, completion pulse, restart lockout
  always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
    if (!Fg_RESETn) begin
      wrap_seen <= 1'b0;
      lock      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      wrap_seen <= wrap_nxt;
      lock      <= lock_nxt;
      Done      <= done_nxt;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/dds_sample_sequencer.md
DDS_SAMPLE_SEQUENCER -- requirements
Module: dds_sample_sequencer

Interface
REQ-001 SHALL have port Fg_CLK, input, 1 bit: single clock; all state on rising edge.
REQ-002 SHALL have port Fg_RESETn, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port Run, input, 1 bit: level; 1 = sequence the waveform, 0 = stop.
REQ-004 SHALL have port DDSMode, input, 3 bits: sample period select.
REQ-005 SHALL have port WaveLast, input, 10 bits: last waveform address; address wraps after it.
REQ-006 SHALL have port MemAddr, output, 10 bits: waveform RAM read address, registered.
REQ-007 SHALL have port MemRdEn, output, 1 bit: RAM read strobe, registered.
REQ-008 SHALL have port MemData, input, 32 bits: RAM data, valid exactly 1 cycle after MemRdEn.
REQ-009 SHALL have port out_1, output, 32 bits: newest sample Y[n-1], registered.
REQ-010 SHALL have port out_2, output, 32 bits: previous sample Y[n-2], registered.
REQ-011 SHALL have port DDSEnable, output, 1 bit: high for the cycle in which out_1/out_2 first show a new pair.
REQ-012 SHALL have port Busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 SHALL map sample period P from DDSMode: 0->1, 1->10, 2->100, 3->1000, 4->10000, 5..7->1, matching the downstream interpolation step 2^29/P.
REQ-014 SHALL implement states IDLE, PRIME, PRIME_WAIT, RUN.
REQ-015 SHALL go IDLE->PRIME when Run=1, driving MemRdEn=1 and MemAddr=0 during PRIME.
REQ-016 SHALL go PRIME->PRIME_WAIT unconditionally, then PRIME_WAIT->RUN, capturing MemData into an internal prefetch register at the PRIME_WAIT edge.
REQ-017 SHALL, in RUN with P>1, run a period counter 0..P-1 starting at 0 on RUN entry; on the edge where the counter equals P-1 (tick), register out_2<=out_1, out_1<=prefetch, DDSEnable=1, MemRdEn=1, MemAddr=next address.
REQ-018 SHALL capture MemData into prefetch on the edge after each MemRdEn cycle.
REQ-019 SHALL hold DDSEnable and MemRdEn low on all non-tick cycles, giving DDSEnable pulses exactly P cycles apart with the first pulse P cycles after RUN entry.
REQ-020 SHALL, in RUN with P=1, hold MemRdEn=1 and increment MemAddr every cycle, with out_2<=out_1 and out_1<=MemData every cycle and DDSEnable=1 continuously.
REQ-021 SHALL compute next address as 0 when the current address equals WaveLast, else the current address+1; WaveLast=0 gives a constant address 0.
REQ-022 SHALL, when Run=0 in any non-IDLE state, enter IDLE on the next edge, drive MemRdEn=0 and DDSEnable=0, hold out_1/out_2, and clear the counter and address to 0.
REQ-023 SHALL, when DDSMode changes during RUN, restart the period counter at 0 with the new P and emit no tick on the change cycle.
REQ-024 SHALL, when WaveLast changes below the current address, wrap to 0 at the next address advance.

Reset
REQ-025 SHALL, on Fg_RESETn=0, immediately force state=IDLE, counter=0, MemAddr=0, MemRdEn=0, prefetch=0, out_1=0, out_2=0, DDSEnable=0, Busy=0, including mid-RUN.
REQ-026 SHALL restart from PRIME at address 0 after reset release with Run=1.

Configuration
REQ-027 SHALL, with DDS_ONESHOT_EN defined, add input OneShot (1 bit) and output Done (1 bit, reset 0); with OneShot=1, after the tick that issues the wrap to address 0, enter IDLE and pulse Done for 1 cycle; without the macro, neither port exists and sequencing is always continuous.

Verification
REQ-028 SHALL verify: RAM[a]=a+100, WaveLast=3, DDSMode=1, Run=1 -> DDSEnable pulses every 10 cycles; successive (out_1,out_2) = (100,0), (101,100), (102,101), (103,102), (100,103).
REQ-029 SHALL verify: DDSMode=0, WaveLast=2 -> DDSEnable constantly 1; out_1 cycles 100,101,102,100 on consecutive cycles.
REQ-030 SHALL verify: DDSMode switched 2->1 at counter=50 -> next DDSEnable 10 cycles after the change, none at the old period.
REQ-031 SHALL verify: Run dropped mid-RUN -> IDLE next edge, Busy=0, out_1/out_2 held, MemAddr=0; Run reasserted -> PRIME reads address 0.
REQ-032 SHALL verify: Fg_RESETn pulsed low mid-RUN, asynchronous to the clock -> all outputs 0 before the next clock edge.
REQ-033 SHALL verify: with DDS_ONESHOT_EN defined, OneShot=1, WaveLast=1, DDSMode=1 -> two DDSEnable pulses, then Done=1 for 1 cycle, then Busy=0.
